// File: rtl/spi_frame_sched_pkg.sv
// spi_sched_pkg: shared types and helpers for the SPI frame scheduler.
//   state_t   - frame sequencer states
//   *_DEF     - default payload width and serializer flush length
//   rr_pick() - round-robin winner search, first set bit after ptr with wrap
package spi_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  localparam int FRAME_BITS_DEF = 40;
  localparam int SETTLE_DEF     = 2;

  // Upper bound on requesters the search loop is unrolled for.
  localparam int RR_MAX = 32;

  // Scan (ptr+1)..(ptr+n) modulo n and return the first requesting index.
  // ptr < n and i <= n keep ptr+i below 2n, so a single subtract wraps.
  // Returns 0 when no bit is set; callers qualify with |req.
  function automatic int rr_pick(input logic [RR_MAX-1:0] req,
                                 input int ptr,
                                 input int n);
    int  idx;
    int  win;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int i = 1; i <= RR_MAX; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i <= n) && req[idx[4:0]]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/spi_frame_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick among N_REQ level requests.
//   sclk, reset_n - clock, synchronous active-low reset
//   req           - request vector
//   advance       - winner is being served; move the pointer to it
//   winner        - index of the current round-robin winner (valid when any)
//   any           - at least one request is set
// The pointer resets to N_REQ-1 so requester 0 is first in line.
module rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  logic [ID_W-1:0]   ptr;
  logic [RR_MAX-1:0] req_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
  end

  assign winner = ID_W'(rr_pick(req_ext, int'(ptr), N_REQ));
  assign any    = |req;

  always_ff @(posedge sclk) begin
    if (!reset_n)     ptr <= ID_W'(N_REQ - 1);
    else if (advance) ptr <= winner;
  end

endmodule

// File: rtl/spi_frame_sched.sv
// spi_frame_sched: shares one 40-bit SPI serializer among N_REQ requesters.
// A round-robin winner's payload is latched in IDLE, then framed as
// LOAD (cs_n low, enable low, one cycle), SHIFT (enable high for
// FRAME_BITS+SETTLE cycles) and GAP (cs_n high for GAP_CYCLES cycles).
//   sclk, reset_n - clock, synchronous active-low reset
//   req, req_data - level requests and packed payloads (slice i per requester)
//   grant, done   - one-hot single-cycle pulses: payload captured / frame shifted
//   spi_enable    - serializer enable
//   spi_bytes     - latched payload, held for the whole frame
//   cs_n          - display chip-select, active low
//   busy          - not IDLE
//   active_id     - current/last granted requester
module spi_frame_sched
  import spi_sched_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int SETTLE     = SETTLE_DEF,
  parameter int GAP_CYCLES = 4,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        sclk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FRAME_BITS-1:0] req_data,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            done,
  output logic                        spi_enable,
  output logic [FRAME_BITS-1:0]       spi_bytes,
  output logic                        cs_n,
  output logic                        busy,
  output logic [ID_W-1:0]             active_id
);

  localparam int SHIFT_LEN = FRAME_BITS + SETTLE;
  localparam int CNT_W     = $clog2(SHIFT_LEN + 1);
  localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gcnt;
  logic [ID_W-1:0]  winner;
  logic             any_req;
  logic             start;
  logic             shift_end;

  assign start     = (state == S_IDLE) && any_req;
  assign shift_end = (state == S_SHIFT) && (cnt == SHIFT_LAST);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .sclk    (sclk),
    .reset_n (reset_n),
    .req     (req),
    .advance (start),
    .winner  (winner),
    .any     (any_req)
  );

  always_ff @(posedge sclk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cs_n       = 1'b1;
    spi_enable = 1'b0;
    busy       = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (any_req) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        cs_n      = 1'b0;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        cs_n       = 1'b0;
        spi_enable = 1'b1;
        // With no gap the IDLE cycle itself is the cs_n-high separation.
        if (cnt == SHIFT_LAST) state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gcnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Payload, id, counters and pulses. spi_bytes only moves on IDLE->LOAD,
  // so req_data may change freely while a frame is in flight.
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      spi_bytes <= '0;
      active_id <= '0;
      grant     <= '0;
      done      <= '0;
      cnt       <= '0;
      gcnt      <= '0;
    end else begin
      grant <= '0;
      done  <= '0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            spi_bytes <= req_data[winner*FRAME_BITS +: FRAME_BITS];
            active_id <= winner;
            grant     <= N_REQ'(1) << winner;
          end
        end
        S_LOAD: cnt <= '0;
        S_SHIFT: begin
          cnt <= cnt + 1'b1;
          if (shift_end) begin
            done <= N_REQ'(1) << active_id;
            gcnt <= '0;
          end
        end
        S_GAP:   gcnt <= gcnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_frame_sched.md
Name: spi_frame_sched

Overview:
- Sequences the 40-bit SPI serializer (`spi_output`) that drives the display link.
- Shares that serializer between N requesters (paddle, ball, score logic) using round-robin arbitration.
- Latches the winner's 40-bit payload, then frames it: load cycle with enable low, 42 enable-high shift cycles, inter-frame gap.
- Drives chip-select and reports grant/done per requester.

Parameters:
- N_REQ, 3, number of requesters (≥1).
- FRAME_BITS, 40, payload width presented to the serializer.
- SETTLE, 2, extra enable-high cycles after the last payload bit (serializer flush).
- GAP_CYCLES, 4, cycles with cs_n high between frames (0 allowed).

Ports:
- sclk  input  1  system/SPI clock; all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- req  input  N_REQ  level request per requester; held until grant seen.
- req_data  input  N_REQ*FRAME_BITS  payloads; requester i uses slice [i*FRAME_BITS +: FRAME_BITS].
- grant  output  N_REQ  one-cycle one-hot pulse when payload is captured.
- done  output  N_REQ  one-cycle one-hot pulse when that frame finishes shifting.
- spi_enable  output  1  to serializer enable.
- spi_bytes  output  FRAME_BITS  to serializer out_bytes; registered, stable for the whole frame.
- cs_n  output  1  display chip-select, active low.
- busy  output  1  high in any state other than IDLE.
- active_id  output  $clog2(N_REQ) (min 1)  index of the current/last granted requester.

Behaviour:
Reset (reset_n low at an edge):
- Outputs: state=IDLE, spi_enable=0, cs_n=1, grant=0, done=0, busy=0, spi_bytes=0, active_id=0.
- Internal: rr pointer = N_REQ-1, so requester 0 has first priority.
- Reset mid-frame abandons the frame: no done pulse, and the frame is not retried.

FSM states: IDLE, LOAD, SHIFT, GAP.

IDLE:
- If req≠0 at an edge, pick the first set bit scanning from (rr+1) mod N_REQ upward with wrap.
- In the same edge: capture that payload into spi_bytes, set active_id, set rr=winner, register grant[winner]=1, go to LOAD.
- If req=0, stay in IDLE with cs_n=1.

LOAD:
- Exactly 1 cycle: cs_n=0, spi_enable=0, so the serializer loads the word.
- Clear counter; go to SHIFT.

SHIFT:
- cs_n=0, spi_enable=1 for exactly FRAME_BITS+SETTLE cycles (42 by default).
- Counter width $clog2(FRAME_BITS+SETTLE+1) bits; counts 0..FRAME_BITS+SETTLE-1.
- On the final count: done[active_id] pulses in the next cycle, and the FSM goes to GAP (or to IDLE if GAP_CYCLES=0).

GAP:
- cs_n=1, spi_enable=0 for GAP_CYCLES cycles, then IDLE.
- Requests are not sampled here; earliest new grant is in the cycle after returning to IDLE.

Data and request rules:
- spi_bytes is never updated outside the IDLE→LOAD edge, so req_data changes during a frame are ignored.
- A requester still asserting req in the cycle after its grant pulse is treated as a new request (it must drop req on seeing grant).
- req deasserted before grant is simply not served; there is no latching of requests.

Simultaneous events:
- Several req bits high: only the round-robin winner is granted; others wait.
- done pulse and GAP entry coincide.

Decomposition:
- Package spi_sched_pkg holds:
  - state enum (IDLE/LOAD/SHIFT/GAP);
  - FRAME_BITS and SETTLE defaults;
  - a function rr_pick(req, ptr) returning the winner index.
- One sub-module is natural: rr_arbiter (combinational pick plus registered pointer, parameterised by N_REQ).
- The FSM, counter and payload register stay in the top module.

Test Plan:
- Single request: reset, then req[0]=1 with payload 40'h8B9BABCBEB at edge t.
  - Required: grant=3'b001 at t+1, cs_n=0 from t+1.
  - spi_enable high t+2..t+43 (42 cycles).
  - done=3'b001 at t+44; cs_n=1 t+44..t+47; busy low at t+48.
- Simultaneous requests: req=3'b111, each requester drops req after its own grant.
  - Required: grants in order 0,1,2, with frames back-to-back separated by 4 gap cycles.
  - active_id follows 0,1,2.
- Fairness: req[0] and req[2] held continuously (reasserted after each grant) for 6 frames.
  - Required: grant order 0,2,0,2,0,2; requester 1 is never granted.
- Payload hold: change req_data[39:0] to 40'h0 during SHIFT.
  - Required: spi_bytes stays 40'h8B9BABCBEB until the next grant.
- Reset mid-frame: assert reset_n=0 at SHIFT count 20 for 1 cycle.
  - Required: next cycle spi_enable=0, cs_n=1, busy=0, and no done pulse.
  - After release, a pending req[1] is granted first-cycle-after-IDLE with rr reset (priority 0 first).
- GAP_CYCLES=0 build: two queued requests.
  - Required: SHIFT→IDLE→LOAD, with cs_n high for exactly 1 cycle (IDLE) between frames.
